ex_muldiv_iter: RTL and testbench

//  Parametrised iterative RV32M/RV64M multiply/divide unit for the execute stage.

---
 rtl/ex_muldiv_iter.sv | 169 ++++++++++++++++
 tb/tb_ex_muldiv_iter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_iter.sv
// Iterative RV32M/RV64M multiply/divide unit for the execute stage.
// Shift-add multiply and restoring divide on operand magnitudes, UNROLL bits per
// CALC cycle, sign fix-up in FIX, one-cycle result pulse in DONE.
// Divide-by-zero and signed overflow bypass the iteration entirely.
module ex_muldiv_iter #(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1,
  parameter int TAG_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [XLEN-1:0]  rs1_i,
  input  logic [XLEN-1:0]  rs2_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic             flush_i,
  output logic             ready_o,
  output logic             busy_o,
  output logic             valid_o,
  output logic [XLEN-1:0]  result_o,
  output logic [TAG_W-1:0] tag_o
);

  localparam int N  = XLEN / UNROLL;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0]   CNT_INIT = CW'(N - 1);
  localparam logic [XLEN-1:0] XMIN     = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [XLEN-1:0]     hi, lo, breg;
  logic [2:0]          op_q;
  logic [TAG_W-1:0]    tag_q;
  logic                neg_q, rneg_q;

  // issue-side decode
  logic                a_sgn, b_sgn, sa, sb, div_zero, div_ovf;
  logic [XLEN-1:0]     amag, bmag, spec_res;
  // iteration / fix-up
  logic [XLEN-1:0]     hi_nx, lo_nx, q_s, r_s, fix_res;
  logic [XLEN:0]       t;
  logic [2*XLEN-1:0]   prod, prod_s;

  // Operand signedness, magnitudes and special-case detection for the incoming op.
  always_comb begin
    a_sgn    = (op_i == 3'd1) || (op_i == 3'd2) || (op_i == 3'd4) || (op_i == 3'd6);
    b_sgn    = (op_i == 3'd1) || (op_i == 3'd4) || (op_i == 3'd6);
    sa       = a_sgn & rs1_i[XLEN-1];
    sb       = b_sgn & rs2_i[XLEN-1];
    amag     = sa ? -rs1_i : rs1_i;
    bmag     = sb ? -rs2_i : rs2_i;
    div_zero = op_i[2] && (rs2_i == '0);
    div_ovf  = op_i[2] && !op_i[0] && (rs1_i == XMIN) && (rs2_i == '1);
    spec_res = '0;
    if (div_zero)     spec_res = op_i[1] ? rs1_i : '1;
    else if (div_ovf) spec_res = op_i[1] ? '0 : rs1_i;
  end

  // UNROLL steps of shift-add (hi:lo = running product) or restoring divide
  // (hi = partial remainder, lo = dividend shifting out / quotient shifting in).
  always_comb begin
    hi_nx = hi;
    lo_nx = lo;
    t     = '0;
    for (int i = 0; i < UNROLL; i++) begin
      if (op_q[2]) begin
        t     = {hi_nx, lo_nx[XLEN-1]};
        lo_nx = {lo_nx[XLEN-2:0], 1'b0};
        if (t >= {1'b0, breg}) begin
          t        = t - {1'b0, breg};
          lo_nx[0] = 1'b1;
        end
        hi_nx = t[XLEN-1:0];
      end else begin
        t     = {1'b0, hi_nx} + (lo_nx[0] ? {1'b0, breg} : '0);
        lo_nx = {t[0], lo_nx[XLEN-1:1]};
        hi_nx = t[XLEN:1];
      end
    end
  end

  // Sign restoration and result selection applied in FIX.
  always_comb begin
    prod   = {hi, lo};
    prod_s = neg_q  ? -prod : prod;
    q_s    = neg_q  ? -lo   : lo;
    r_s    = rneg_q ? -hi   : hi;
    case (op_q)
      3'd0:              fix_res = prod_s[XLEN-1:0];
      3'd1, 3'd2, 3'd3:  fix_res = prod_s[2*XLEN-1:XLEN];
      3'd4, 3'd5:        fix_res = q_s;
      default:           fix_res = r_s;
    endcase
  end

  // Control FSM with registered handshake outputs; flush overrides everything but reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      hi       <= '0;
      lo       <= '0;
      breg     <= '0;
      op_q     <= '0;
      tag_q    <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      ready_o  <= 1'b1;
      busy_o   <= 1'b0;
      valid_o  <= 1'b0;
      result_o <= '0;
      tag_o    <= '0;
    end else if (flush_i) begin
      state   <= IDLE;
      ready_o <= 1'b1;
      busy_o  <= 1'b0;
      valid_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          valid_o <= 1'b0;
          if (start_i) begin
            op_q    <= op_i;
            tag_q   <= tag_i;
            neg_q   <= sa ^ sb;
            rneg_q  <= sa;
            hi      <= '0;
            lo      <= amag;
            breg    <= bmag;
            cnt     <= CNT_INIT;
            ready_o <= 1'b0;
            if (div_zero || div_ovf) begin
              state    <= DONE;
              valid_o  <= 1'b1;
              result_o <= spec_res;
              tag_o    <= tag_i;
            end else begin
              state  <= CALC;
              busy_o <= 1'b1;
            end
          end
        end
        CALC: begin
          hi <= hi_nx;
          lo <= lo_nx;
          if (cnt == '0) state <= FIX;
          else           cnt   <= cnt - CW'(1);
        end
        FIX: begin
          state    <= DONE;
          busy_o   <= 1'b0;
          valid_o  <= 1'b1;
          result_o <= fix_res;
          tag_o    <= tag_q;
        end
        DONE: begin
          state   <= IDLE;
          valid_o <= 1'b0;
          ready_o <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv_iter.sv
// Bench for ex_muldiv_iter: two instances (UNROLL=1 and UNROLL=4) share the same
// stimulus; results, tags and latencies are checked against an arithmetic model.
module tb_ex_muldiv_iter;

  localparam int N1 = 32;
  localparam int N4 = 8;

  logic        clk, rst, start, flush;
  logic [2:0]  op;
  logic [31:0] rs1, rs2;
  logic [4:0]  tag;
  logic        rdy1, bsy1, vld1, rdy4, bsy4, vld4;
  logic [31:0] res1, res4;
  logic [4:0]  tg1, tg4;

  int n_cmp = 0;
  int n_err = 0;

  ex_muldiv_iter #(.XLEN(32), .UNROLL(1), .TAG_W(5)) u1 (
    .clk(clk), .rst(rst), .start_i(start), .op_i(op), .rs1_i(rs1), .rs2_i(rs2),
    .tag_i(tag), .flush_i(flush), .ready_o(rdy1), .busy_o(bsy1), .valid_o(vld1),
    .result_o(res1), .tag_o(tg1));

  ex_muldiv_iter #(.XLEN(32), .UNROLL(4), .TAG_W(5)) u4 (
    .clk(clk), .rst(rst), .start_i(start), .op_i(op), .rs1_i(rs1), .rs2_i(rs2),
    .tag_i(tag), .flush_i(flush), .ready_o(rdy4), .busy_o(bsy4), .valid_o(vld4),
    .result_o(res4), .tag_o(tg4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // RISC-V M semantics via 64-bit arithmetic
  function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, s;
    logic [63:0] u;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    case (o)
      3'd0: begin u = {32'b0, a} * {32'b0, b}; return u[31:0]; end
      3'd1: begin s = sa * sb; return s[63:32]; end
      3'd2: begin s = sa * longint'({32'b0, b}); return s[63:32]; end
      3'd3: begin u = {32'b0, a} * {32'b0, b}; return u[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
        s = sa / sb; return s[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        s = sa % sb; return s[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    return o[2] && (b == 0 || (!o[0] && a == 32'h80000000 && b == 32'hFFFFFFFF));
  endfunction

  function automatic logic [31:0] pick();
    logic [31:0] c [5] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
    case ($urandom_range(0, 3))
      0: return c[$urandom_range(0, 4)];
      1: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  // Issue one op to both instances and check result, tag, latency and the pulse shape.
  task automatic run_op(input string nm, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] tg);
    logic [31:0] exp;
    int n, l1, l4, e1, e4;
    bit g1, g4;
    logic [31:0] r1, r4;
    logic [4:0]  t1, t4;
    exp = ref_model(o, a, b);
    e1  = is_special(o, a, b) ? 1 : N1 + 2;
    e4  = is_special(o, a, b) ? 1 : N4 + 2;
    @(negedge clk);
    start = 1'b1; op = o; rs1 = a; rs2 = b; tag = tg;
    @(posedge clk); #1;
    start = 1'b0; op = 3'($urandom); rs1 = $urandom; rs2 = $urandom; tag = 5'($urandom);
    n = 1; g1 = 0; g4 = 0; l1 = 0; l4 = 0; r1 = 0; r4 = 0; t1 = 0; t4 = 0;
    while (!(g1 && g4) && n < 100) begin
      if (vld1 && !g1) begin g1 = 1; l1 = n; r1 = res1; t1 = tg1; end
      if (vld4 && !g4) begin g4 = 1; l4 = n; r4 = res4; t4 = tg4; end
      if (!(g1 && g4)) begin @(posedge clk); #1; n++; end
    end
    chk({nm, "_valid_u1"}, 64'(g1), 64'd1);
    chk({nm, "_valid_u4"}, 64'(g4), 64'd1);
    chk({nm, "_res_u1"}, 64'(r1), 64'(exp));
    chk({nm, "_res_u4"}, 64'(r4), 64'(exp));
    chk({nm, "_tag_u1"}, 64'(t1), 64'(tg));
    chk({nm, "_tag_u4"}, 64'(t4), 64'(tg));
    chk({nm, "_lat_u1"}, 64'(l1), 64'(e1));
    chk({nm, "_lat_u4"}, 64'(l4), 64'(e4));
    @(posedge clk); #1;
    chk({nm, "_idle"}, {60'b0, rdy1, rdy4, vld1, vld4}, 64'b1100);
  endtask

  initial begin
    int n, cnt;
    logic [2:0]  o;
    logic [31:0] a, b;
    rst = 1'b0; start = 1'b0; flush = 1'b0; op = '0; rs1 = '0; rs2 = '0; tag = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctl", {59'b0, rdy1, bsy1, vld1, rdy4, bsy4, vld4}, 64'b100100);
    chk("reset_data", {27'b0, res1, tg1}, 64'd0);
    chk("reset_data4", {27'b0, res4, tg4}, 64'd0);
    @(negedge clk); rst = 1'b1;

    // directed cases
    run_op("mul_neg",    3'd0, 32'd7,        32'hFFFFFFFD, 5'd1);
    run_op("mulh_min",   3'd1, 32'h80000000, 32'h80000000, 5'd2);
    run_op("mulhu_max",  3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3);
    run_op("mulhsu",     3'd2, 32'hFFFFFFFE, 32'hFFFFFFFF, 5'd4);
    run_op("div_neg",    3'd4, 32'hFFFFFFF9, 32'd2,        5'd5);
    run_op("rem_neg",    3'd6, 32'hFFFFFFF9, 32'd2,        5'd6);
    run_op("divu_zero",  3'd5, 32'h80000000, 32'd0,        5'd7);
    run_op("remu_zero",  3'd7, 32'h12345678, 32'd0,        5'd8);
    run_op("div_ovf",    3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd21);
    run_op("rem_ovf",    3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd22);

    // flush during CALC cycle 5 of a DIVU
    @(negedge clk); start = 1'b1; op = 3'd5; rs1 = 32'd1000; rs2 = 32'd7; tag = 5'd11;
    @(posedge clk); #1; start = 1'b0;
    repeat (4) @(posedge clk);
    #1; chk("flush_busy", {62'b0, bsy1, bsy4}, 64'b11);
    flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    chk("flush_ready", {60'b0, rdy1, rdy4, vld1, vld4}, 64'b1100);
    cnt = 0;
    repeat (40) begin @(posedge clk); #1; if (vld1 || vld4) cnt++; end
    chk("flush_no_valid", 64'(cnt), 64'd0);
    run_op("mul_after_flush", 3'd0, 32'd12345, 32'd678, 5'd12);

    // flush and start together while IDLE: flush wins
    @(negedge clk); start = 1'b1; flush = 1'b1; op = 3'd0; rs1 = 32'd3; rs2 = 32'd3;
    @(posedge clk); #1; start = 1'b0; flush = 1'b0;
    chk("flush_start_idle", {60'b0, rdy1, bsy1, rdy4, bsy4}, 64'b1010);

    // flush in DONE: the committed pulse stays, then idle
    @(negedge clk); start = 1'b1; op = 3'd5; rs1 = 32'd9; rs2 = 32'd0; tag = 5'd13;
    @(posedge clk); #1; start = 1'b0; flush = 1'b1;
    chk("flush_done_valid", {62'b0, vld1, vld4}, 64'b11);
    chk("flush_done_res", 64'(res1), 64'hFFFFFFFF);
    @(posedge clk); #1; flush = 1'b0;
    chk("flush_done_after", {60'b0, rdy1, rdy4, vld1, vld4}, 64'b1100);

    // back-to-back on UNROLL=4 (u1 accepts the MUL and ignores the DIVU)
    @(negedge clk); start = 1'b1; op = 3'd0; rs1 = 32'hDEADBEEF; rs2 = 32'h1234; tag = 5'd3;
    @(posedge clk); #1; start = 1'b0; n = 1;
    while (!vld4 && n < 40) begin @(posedge clk); #1; n++; end
    chk("b2b_lat_a", 64'(n), 64'(N4 + 2));
    chk("b2b_res_a", 64'(res4), 64'(ref_model(3'd0, 32'hDEADBEEF, 32'h1234)));
    chk("b2b_tag_a", 64'(tg4), 64'd3);
    @(posedge clk); #1;
    start = 1'b1; op = 3'd5; rs1 = 32'hFFFF0000; rs2 = 32'd37; tag = 5'd9;
    @(posedge clk); #1; start = 1'b0; n = 1;
    while (!vld4 && n < 40) begin @(posedge clk); #1; n++; end
    chk("b2b_lat_b", 64'(n), 64'(N4 + 2));
    chk("b2b_res_b", 64'(res4), 64'(ref_model(3'd5, 32'hFFFF0000, 32'd37)));
    chk("b2b_tag_b", 64'(tg4), 64'd9);
    n = 0;
    while (!vld1 && n < 60) begin @(posedge clk); #1; n++; end
    chk("busy_ignore_res", 64'(res1), 64'(ref_model(3'd0, 32'hDEADBEEF, 32'h1234)));
    chk("busy_ignore_tag", 64'(tg1), 64'd3);
    cnt = 0;
    repeat (40) begin @(posedge clk); #1; if (vld1) cnt++; end
    chk("busy_ignore_nodup", 64'(cnt), 64'd0);

    // reset mid-op
    @(negedge clk); start = 1'b1; op = 3'd1; rs1 = $urandom; rs2 = $urandom; tag = 5'd14;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0; #1;
    chk("rst_midop", {58'b0, rdy1, bsy1, vld1, rdy4, bsy4, vld4}, 64'b100100);
    chk("rst_midop_data", {27'b0, res1, tg1}, 64'd0);
    @(negedge clk); rst = 1'b1;
    cnt = 0;
    repeat (40) begin @(posedge clk); #1; if (vld1 || vld4) cnt++; end
    chk("rst_no_valid", 64'(cnt), 64'd0);

    // randomized ops
    for (int i = 0; i < 30; i++) begin
      o = 3'($urandom);
      a = pick();
      b = pick();
      run_op($sformatf("rnd%0d_op%0d", i, o), o, a, b, 5'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
